// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_START_PC = 32'h8002_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Redirect targets ignore the byte offset within the word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head, used for the
// instruction buffer and the in-order PC tag queue of the fetch stage.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    // Clear wins over everything; a push into a full FIFO is only legal
    // when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);

    // Storage array: written on push, no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (!do_push && do_pop) count_reg <= count_reg - CW'(1);
        end
    end

    // Overflow means the upstream credit logic is broken.
    always_ff @(posedge clock) begin
        if (!reset && !clear) begin
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads under a
// credit limit, tags responses with their PC and buffers them for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_PC  = DEFAULT_START_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] insn,
    output logic        insn_valid,
    output logic [31:0] pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   pc_hold_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] outstanding_next;

    logic [63:0]   buf_head;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    logic [31:0]   tag_head;
    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_count;

    logic          pop;
    logic          accept;
    logic          push;
    logic [CW:0]   credit_used;
    logic          unused_ok;

    assign insn_valid = !buf_empty;
    assign insn       = buf_empty ? NOP_INSN : buf_head[31:0];
    assign pc         = buf_empty ? pc_hold_reg : buf_head[63:32];
    assign mem_addr   = fetch_pc_reg;

    assign pop    = insn_valid && !stall;
    assign accept = mem_req && mem_ready;
    // Responses are only kept while running and not being redirected.
    assign push   = mem_resp_valid && (state_reg == ST_RUN) && !redirect_valid;

    // Slots already claimed after this cycle's pop: in-flight reads plus
    // buffered entries must stay within the buffer depth.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
    assign mem_req     = (state_reg == ST_RUN) && enable && !redirect_valid
                         && (credit_used < (CW+1)'(BUF_DEPTH));

    assign unused_ok = ^{buf_full, tag_full, tag_empty, tag_count};

    // Net change of in-flight reads this cycle.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !mem_resp_valid)      outstanding_next = outstanding_reg + CW'(1);
        else if (!accept && mem_resp_valid) outstanding_next = outstanding_reg - CW'(1);
    end

    // Control FSM: IDLE until enabled, RUN issues, FLUSH drains stale reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        state_reg <= (outstanding_next != '0) ? ST_FLUSH : ST_RUN;
                    end else if (!enable && outstanding_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (outstanding_next == '0) state_reg <= ST_RUN;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Fetch PC, in-flight count and the PC shown while the buffer is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_reg    <= START_PC;
            outstanding_reg <= '0;
            pc_hold_reg     <= START_PC;
        end else begin
            if (redirect_valid)  fetch_pc_reg <= word_align(redirect_pc);
            else if (accept)     fetch_pc_reg <= fetch_pc_reg + 32'd4;
            outstanding_reg <= outstanding_next;
            if (!buf_empty) pc_hold_reg <= buf_head[63:32];
        end
    end

    // PC of every accepted read, consumed in order as responses return.
    fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_tag_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .push      (accept),
        .push_data (fetch_pc_reg),
        .pop       (mem_resp_valid),
        .head_data (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // {pc, insn} entries waiting for decode; a redirect empties it.
    fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_insn_buf (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({tag_head, mem_resp_data}),
        .pop       (pop),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and an
// instruction-stream reference model (expected PC sequence per redirect).
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h8002_0000;
    localparam int          DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] insn;
    logic        insn_valid;
    logic [31:0] pc;

    fetch_unit #(.START_PC(START), .BUF_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .insn           (insn),
        .insn_valid     (insn_valid),
        .pc             (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory model state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          lat_min = 1;
    int          lat_max = 1;
    int          cyc = 0;

    // Reference model state
    logic [31:0] m_fetch_pc;
    logic [31:0] m_exp_pc;
    bit          prev_hold = 0;
    logic [31:0] prev_pc;
    logic [31:0] prev_insn;
    int          pops = 0;

    // Samples of the current cycle
    logic        s_req, s_valid, s_acc;
    logic [31:0] s_addr, s_insn, s_pc;

    // One clock cycle: memory drives its response, outputs are sampled
    // mid-cycle and checked against the model, then the model advances.
    task automatic step();
        @(negedge clock);
        if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mq_addr[0] ^ 32'hFFFF_FFFF;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
        #1;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = insn_valid;
        s_insn  = insn;
        s_pc    = pc;
        s_acc   = s_req && mem_ready;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            m_fetch_pc = START;
            m_exp_pc   = START;
            prev_hold  = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, s_valid}, 32'd1);
                check("hold_pc", s_pc, prev_pc);
                check("hold_insn", s_insn, prev_insn);
            end
            if (redirect_valid) check("req_low_on_redirect", {31'd0, s_req}, 32'd0);
            if (s_req) check("mem_addr", s_addr, m_fetch_pc);
            if (!s_valid) check("nop_when_empty", s_insn, 32'd0);
            if (s_valid && !stall && !redirect_valid) begin
                check("pop_pc", s_pc, m_exp_pc);
                check("pop_insn", s_insn, m_exp_pc ^ 32'hFFFF_FFFF);
                m_exp_pc = m_exp_pc + 32'd4;
                pops++;
            end
            if (s_acc) begin
                mq_addr.push_back(s_addr);
                mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
                m_exp_pc   = {redirect_pc[31:2], 2'b00};
            end
            if (mem_resp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            check("credit_limit", {31'd0, (mq_addr.size() <= DEPTH)}, 32'd1);
            prev_hold = s_valid && stall && !redirect_valid;
            prev_pc   = s_pc;
            prev_insn = s_insn;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int          n;
        bit          found;
        logic [31:0] held_pc;
        logic [31:0] a0;

        reset          = 1'b1;
        enable         = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ready      = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset values
        step();
        step();
        check("rst_mem_req", {31'd0, s_req}, 32'd0);
        check("rst_mem_addr", s_addr, START);
        check("rst_insn", s_insn, 32'd0);
        check("rst_insn_valid", {31'd0, s_valid}, 32'd0);
        check("rst_pc", s_pc, START);

        // Throughput with 1-cycle memory
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 0) check("first_cycle_no_req", {31'd0, s_req}, 32'd0);
            if (k == 1) begin
                check("first_req", {31'd0, s_req}, 32'd1);
                check("first_addr", s_addr, START);
            end
            if (k >= 3) check("stream_valid", {31'd0, s_valid}, 32'd1);
        end
        $display("[TB] stream: %0d insns popped, next pc %h", pops, m_exp_pc);

        // Stall three cycles with the buffer filling up
        stall = 1'b1;
        held_pc = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) held_pc = s_pc;
            check("stall_req_low", {31'd0, s_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check("stall_release_pc", s_pc, held_pc);
        step();
        check("after_stall_pc", s_pc, held_pc + 32'd4);
        $display("[TB] stall: held pc %h", held_pc);

        // Redirect with two reads in flight
        lat_min = 4;
        lat_max = 4;
        n = 0;
        while (mq_addr.size() != 2 && n < 50) begin
            step();
            n++;
        end
        check("wait_outstanding2", mq_addr.size(), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0103;
        step();
        redirect_valid = 1'b0;
        lat_min = 1;
        lat_max = 1;
        n = 0;
        found = 0;
        while (!found && n < 60) begin
            step();
            found = s_valid;
            n++;
        end
        check("redirect_valid_seen", {31'd0, found}, 32'd1);
        check("redirect_first_pc", s_pc, 32'h8002_0100);
        $display("[TB] redirect: first pc %h after %0d cycles", s_pc, n);

        // mem_ready low for four cycles
        n = 0;
        found = 0;
        while (!found && n < 40) begin
            step();
            found = s_req;
            n++;
        end
        mem_ready = 1'b0;
        a0 = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) a0 = s_addr;
            check("ready_low_req", {31'd0, s_req}, 32'd1);
            if (k > 0) check("ready_low_addr_stable", s_addr, a0);
        end
        mem_ready = 1'b1;
        step();
        check("ready_accept_addr", s_addr, a0);
        n = 0;
        found = 0;
        while (!found && n < 20) begin
            step();
            found = s_req;
            n++;
        end
        check("ready_next_addr", s_addr, a0 + 32'd4);
        $display("[TB] ready stall: addr %h then %h", a0, s_addr);

        // Fetch PC wraps past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n = 0;
        found = 0;
        while (!found && n < 30) begin
            step();
            found = s_acc && (s_addr == 32'hFFFF_FFFC);
            n++;
        end
        check("wrap_accept_seen", {31'd0, found}, 32'd1);
        n = 0;
        found = 0;
        while (!found && n < 20) begin
            step();
            found = s_req;
            n++;
        end
        check("wrap_addr", s_addr, 32'h0000_0000);
        $display("[TB] wrap: addr after FFFFFFFC is %h", s_addr);

        // Reset while work is buffered and in flight
        lat_min = 3;
        lat_max = 3;
        stall   = 1'b1;
        for (int k = 0; k < 8; k++) step();
        reset = 1'b1;
        step();
        step();
        check("mid_rst_valid", {31'd0, s_valid}, 32'd0);
        check("mid_rst_insn", s_insn, 32'd0);
        check("mid_rst_pc", s_pc, START);
        check("mid_rst_req", {31'd0, s_req}, 32'd0);
        check("mid_rst_addr", s_addr, START);
        $display("[TB] mid-reset: pc %h valid %0d", s_pc, s_valid);
        reset = 1'b0;
        stall = 1'b0;

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        n = pops;
        for (int k = 0; k < 3000; k++) begin
            stall          = ($urandom_range(3, 0) == 0);
            mem_ready      = ($urandom_range(3, 0) != 0);
            enable         = ($urandom_range(15, 0) != 0);
            redirect_valid = ($urandom_range(39, 0) == 0);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        check("random_progress", {31'd0, ((pops - n) > 300)}, 32'd1);
        $display("[TB] random: %0d insns popped", pops - n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
